// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, op width and sequencer FSM state encoding.
// Used by the sequential ALU front-end and by any combinational ALU or bench that speaks the same op set.
// Pure definitions; no logic.
package alu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [OP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [OP_W-1:0] ALU_XOR = 3'b100;
  localparam logic [OP_W-1:0] ALU_SLL = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Codes 110/111 are reserved and reported as errors.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op <= ALU_SLL);
  endfunction

endpackage

// File: rtl/alu_seq_unit.sv
// Handshaked ALU: one request in, one response out; a single op in flight at a time.
// Latency accept->rsp_valid: 1 cycle, or 1+shamt cycles for SLL with a non-zero shift.
// Request side stalls (req_ready=0) until the response handshake; response held under backpressure.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [OP_W-1:0]  req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);

  localparam int SH_W = $clog2(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic             rdy_en;
  logic [WIDTH-1:0] result_q;
  logic             err_q;
  logic [SH_W-1:0]  cnt_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] alu_res;
  logic [SH_W-1:0]  shamt;
  logic             accept;
  logic             rsp_fire;
  logic             start_shift;

  // Only the low log2(WIDTH) bits of b select the shift distance.
  assign shamt       = req_b[SH_W-1:0];
  assign accept      = req_valid && req_ready;
  assign rsp_fire    = rsp_valid && rsp_ready;
  assign start_shift = (req_op == ALU_SLL) && (shamt != '0);

  // Single-cycle result; SLL loads the unshifted operand and the FSM shifts it one bit per cycle.
  always_comb begin
    alu_res = '0;
    case (req_op)
      ALU_ADD: alu_res = req_a + req_b;
      ALU_SUB: alu_res = req_a - req_b;
      ALU_AND: alu_res = req_a & req_b;
      ALU_OR:  alu_res = req_a | req_b;
      ALU_XOR: alu_res = req_a ^ req_b;
      ALU_SLL: alu_res = req_a;
      default: alu_res = '0;
    endcase
  end

  // State register; rdy_en keeps req_ready low while reset is asserted and for the release edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      rdy_en <= 1'b0;
    end else begin
      state  <= state_nxt;
      rdy_en <= 1'b1;
    end
  end

  // Next-state: shift until the counter has one step left, then present the response.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = start_shift ? ST_SHIFT : ST_RESP;
      ST_SHIFT: if (cnt_q == SH_W'(1)) state_nxt = ST_RESP;
      ST_RESP:  if (rsp_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Handshake and response outputs decoded from state.
  always_comb begin
    req_ready  = rdy_en && (state == ST_IDLE);
    rsp_valid  = (state == ST_RESP);
    rsp_result = result_q;
    rsp_zero   = (state == ST_RESP) && (result_q == '0);
    rsp_err    = err_q;
    op_count   = count_q;
  end

  // Datapath: capture operands on accept, shift in SHIFT, count completed handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      count_q  <= '0;
    end else begin
      if (accept) begin
        result_q <= alu_res;
        err_q    <= !op_legal(req_op);
        cnt_q    <= start_shift ? shamt : '0;
      end else if (state == ST_SHIFT) begin
        result_q <= result_q << 1;
        cnt_q    <= cnt_q - SH_W'(1);
      end
      if (rsp_fire) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit with a queue-based scoreboard of expected responses.
// Counter width is reduced so the wrap-around case stays short.
module tb_alu_seq_unit;

  localparam int WIDTH = 32;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [2:0]       req_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_err;
  logic [CNT_W-1:0] op_count;

  alu_seq_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             err;
    int               lat;
  } exp_t;

  exp_t             exp_q[$];
  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] exp_count = '0;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    exp_t e;
    e.err = 1'b0;
    e.lat = 1;
    case (op)
      3'b000: e.res = a + b;
      3'b001: e.res = a - b;
      3'b010: e.res = a & b;
      3'b011: e.res = a | b;
      3'b100: e.res = a ^ b;
      3'b101: begin
        e.res = a << b[4:0];
        e.lat = 1 + int'(b[4:0]);
      end
      default: begin
        e.res = '0;
        e.err = 1'b1;
      end
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  task automatic chk(input string tag, input string what, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s.%s: observed %0h expected %0h", tag, what, got, exp);
    end
  endtask

  // Present one request and hold it until the accept edge, then scramble the inputs.
  task automatic send(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    int w = 0;
    while (!req_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    chk(tag, "req_ready", req_ready, 1);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    exp_q.push_back(model(a, b, op));
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a     = $urandom;
    req_b     = $urandom;
    req_op    = 3'($urandom_range(0, 7));
  endtask

  // Wait for the response, compare against the scoreboard, optionally stall it, then complete it.
  task automatic recv(input string tag, input int hold, input logic poke);
    exp_t e;
    int   lat = 1;
    int   ready_bad = 0;
    int   stable_bad = 0;
    while (!rsp_valid && lat <= WIDTH + 4) begin
      if (req_ready) ready_bad++;
      @(posedge clk); #1;
      lat++;
    end
    e = exp_q.pop_front();
    chk(tag, "rsp_valid", rsp_valid, 1);
    chk(tag, "latency", lat, e.lat);
    chk(tag, "result", rsp_result, e.res);
    chk(tag, "zero", rsp_zero, e.zero);
    chk(tag, "err", rsp_err, e.err);
    chk(tag, "ready_low_busy", ready_bad, 0);
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        req_valid = 1'b1;
        req_a     = 32'd1;
        req_b     = 32'd1;
        req_op    = 3'b000;
      end
      @(posedge clk); #1;
      if (!(rsp_valid === 1'b1 && rsp_result === e.res && rsp_zero === e.zero &&
            rsp_err === e.err && req_ready === 1'b0)) stable_bad++;
    end
    req_valid = 1'b0;
    if (hold > 0) chk(tag, "stable_under_backpressure", stable_bad, 0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_count++;
    chk(tag, "op_count", op_count, exp_count);
    chk(tag, "rsp_valid_after", rsp_valid, 0);
    @(posedge clk); #1;
    chk(tag, "no_extra_rsp", rsp_valid, 0);
  endtask

  initial begin
    exp_t e;
    int   n_sent;
    int   n_recv;
    int   bad;
    int   cyc;
    logic mid_done;
    logic [31:0] a;
    logic [31:0] b;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset", "req_ready", req_ready, 0);
    chk("reset", "rsp_valid", rsp_valid, 0);
    chk("reset", "rsp_result", rsp_result, 0);
    chk("reset", "rsp_zero", rsp_zero, 0);
    chk("reset", "rsp_err", rsp_err, 0);
    chk("reset", "op_count", op_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("release", "req_ready", req_ready, 1);

    send("add", 32'd10, 32'd5, 3'b000);            recv("add", 0, 1'b0);
    send("sub", 32'd20, 32'd8, 3'b001);            recv("sub", 0, 1'b0);
    send("sub_neg", 32'd0, 32'd1, 3'b001);         recv("sub_neg", 0, 1'b0);
    send("sub_zero", 32'd7, 32'd7, 3'b001);        recv("sub_zero", 0, 1'b0);
    send("and", 32'hAA, 32'hCC, 3'b010);           recv("and", 0, 1'b0);
    send("or", 32'hAA, 32'hCC, 3'b011);            recv("or", 0, 1'b0);
    send("xor", 32'hAA, 32'hCC, 3'b100);           recv("xor", 0, 1'b0);
    send("sll3", 32'd1, 32'd3, 3'b101);            recv("sll3", 0, 1'b0);
    send("sll0", 32'd1, 32'd0, 3'b101);            recv("sll0", 0, 1'b0);
    send("sll35", 32'd1, 32'd35, 3'b101);          recv("sll35", 0, 1'b0);
    send("sll31", 32'd1, 32'd31, 3'b101);          recv("sll31", 0, 1'b0);
    send("sll_pat", 32'hDEAD_BEEF, 32'd4, 3'b101); recv("sll_pat", 2, 1'b0);
    send("illegal", 32'h1234, 32'h5678, 3'b110);   recv("illegal", 10, 1'b1);
    send("illegal7", 32'hFFFF, 32'h1, 3'b111);     recv("illegal7", 0, 1'b0);

    // Reset while a long shift is in flight: the op must vanish.
    send("rst_mid", 32'd1, 32'd20, 3'b101);
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("rst_mid", "rsp_valid", rsp_valid, 0);
    chk("rst_mid", "req_ready", req_ready, 0);
    chk("rst_mid", "op_count", op_count, 0);
    exp_q.delete();
    exp_count = '0;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) bad++;
    end
    chk("rst_mid", "no_rsp_after_release", bad, 0);
    chk("rst_mid", "req_ready_after", req_ready, 1);
    chk("rst_mid", "op_count_after", op_count, 0);

    // Back-to-back ADDs with the consumer always ready: counter wraps to zero.
    rsp_ready = 1'b1;
    n_sent    = 0;
    n_recv    = 0;
    bad       = 0;
    cyc       = 0;
    mid_done  = 1'b0;
    while (n_recv < (1 << CNT_W) && cyc < 4000) begin
      if (n_recv == (1 << CNT_W) - 1 && !mid_done) begin
        chk("wrap", "count_before_wrap", op_count, 64'((1 << CNT_W) - 1));
        mid_done = 1'b1;
      end
      if (rsp_valid) begin
        e = exp_q.pop_front();
        if (rsp_result !== e.res || rsp_err !== e.err || rsp_zero !== e.zero) bad++;
        n_recv++;
        exp_count++;
      end
      if (req_ready && n_sent < (1 << CNT_W)) begin
        a = $urandom;
        b = $urandom;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_op    = 3'b000;
        exp_q.push_back(model(a, b, 3'b000));
        n_sent++;
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("wrap", "responses", n_recv, 1 << CNT_W);
    chk("wrap", "results", bad, 0);
    chk("wrap", "op_count", op_count, exp_count);
    chk("wrap", "op_count_zero", op_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
